// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// Transmit half of the UART peripheral. Shifts one byte out on tx_o as an
// asynchronous frame: a start bit, then 8 data bits LSB first, then an
// optional parity bit, then 1 or 2 stop bits.
// tx_rdy_o pulses for one cycle when a frame ends. That pulse clears the send
// bit in the control register. The FSM then waits in WAIT_CLR until send_i
// drops, so the same request cannot start a second frame.
// All outputs come straight from flops. The next-state logic computes the
// value each output takes after the coming edge.

module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 868,
   parameter bit PARITY_EN    = 1'b0,
   parameter bit PARITY_ODD   = 1'b0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       send_i,
   input  logic [7:0] data_i,
   output logic       tx_o,
   output logic       busy_o,
   output logic       tx_rdy_o
);

   localparam int               CNT_W     = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_CLR
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic             stop_q, stop_d;
   logic [7:0]       shadow_q, shadow_d;
   logic             tx_d, busy_d, rdy_d;
   logic             bit_end;

   assign bit_end = (cnt_q == CNT_LAST);

   // State register and registered outputs; a synchronous active-low reset aborts any frame in flight
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         stop_q   <= 1'b0;
         shadow_q <= '0;
         tx_o     <= 1'b1;
         busy_o   <= 1'b0;
         tx_rdy_o <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         stop_q   <= stop_d;
         shadow_q <= shadow_d;
         tx_o     <= tx_d;
         busy_o   <= busy_d;
         tx_rdy_o <= rdy_d;
      end
   end

   // Next state plus the next value of each output; the baud counter restarts at every bit boundary and state entry
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      idx_d    = idx_q;
      stop_d   = stop_q;
      shadow_d = shadow_q;
      tx_d     = tx_o;
      busy_d   = busy_o;
      rdy_d    = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (send_i) begin
               shadow_d = data_i;
               state_d  = START;
               tx_d     = 1'b0;
               busy_d   = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = DATA;
               tx_d    = shadow_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (idx_q == 3'd7) begin
                  if (PARITY_EN) begin
                     state_d = PARITY;
                     tx_d    = (^shadow_q) ^ PARITY_ODD;
                  end else begin
                     state_d = STOP;
                     stop_d  = 1'b0;
                     tx_d    = 1'b1;
                  end
               end else begin
                  idx_d = idx_q + 3'd1;
                  tx_d  = shadow_q[idx_q + 3'd1];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               cnt_d   = '0;
               stop_d  = 1'b0;
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               if (stop_q == STOP_LAST) begin
                  state_d = WAIT_CLR;
                  busy_d  = 1'b0;
                  rdy_d   = 1'b1;
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end
         end
         WAIT_CLR: begin
            cnt_d  = '0;
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (!send_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer
// Four transmitters share one set of inputs:
//   dut 0: 4 clk/bit, no parity, 1 stop bit
//   dut 1: 4 clk/bit, even parity, 1 stop bit
//   dut 2: 4 clk/bit, odd parity, 1 stop bit
//   dut 3: 1 clk/bit, no parity, 2 stop bits
// A frame-level reference model predicts tx/busy/rdy for every cycle of every
// instance. Directed checks cover latency, pulse counts, parity, shadowing,
// reset abort and the back-to-back gap.

module tb_uart_tx_serializer;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       send_i;
   logic [7:0] data_i;
   logic [3:0] tx_w, busy_w, rdy_w;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   bit check_en    = 1'b0;

   // reference model state, one slot per instance
   int         phase[4];
   int         k[4];
   logic [11:0] frame[4];
   logic       exp_tx[4];
   logic       exp_busy[4];
   logic       exp_rdy[4];

   always #5 clk_i = ~clk_i;

   uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut0 (
      .clk_i(clk_i), .reset_i(reset_i), .send_i(send_i), .data_i(data_i),
      .tx_o(tx_w[0]), .busy_o(busy_w[0]), .tx_rdy_o(rdy_w[0]));
   uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut1 (
      .clk_i(clk_i), .reset_i(reset_i), .send_i(send_i), .data_i(data_i),
      .tx_o(tx_w[1]), .busy_o(busy_w[1]), .tx_rdy_o(rdy_w[1]));
   uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) dut2 (
      .clk_i(clk_i), .reset_i(reset_i), .send_i(send_i), .data_i(data_i),
      .tx_o(tx_w[2]), .busy_o(busy_w[2]), .tx_rdy_o(rdy_w[2]));
   uart_tx_serializer #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) dut3 (
      .clk_i(clk_i), .reset_i(reset_i), .send_i(send_i), .data_i(data_i),
      .tx_o(tx_w[3]), .busy_o(busy_w[3]), .tx_rdy_o(rdy_w[3]));

   function automatic int cpbOf(input int i);
      return (i == 3) ? 1 : 4;
   endfunction

   function automatic int peOf(input int i);
      return (i == 1 || i == 2) ? 1 : 0;
   endfunction

   function automatic int stopsOf(input int i);
      return (i == 3) ? 2 : 1;
   endfunction

   function automatic int frameLen(input int i);
      return cpbOf(i) * (9 + peOf(i) + stopsOf(i));
   endfunction

   // line value per bit slot: start, D0..D7, optional parity, stop bits (all ones)
   function automatic logic [11:0] buildFrame(input int i, input logic [7:0] d);
      logic [11:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = d;
      if (peOf(i) == 1) f[9] = (^d) ^ (i == 2);
      return f;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [7:0] d);
      @(negedge clk_i);
      send_i = s;
      data_i = d;
   endtask

   // cycle counter and frame-level reference model, advanced on every active edge
   always @(posedge clk_i) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 4; i++) begin
         if (!reset_i) begin
            phase[i]    = 0;
            exp_tx[i]   = 1'b1;
            exp_busy[i] = 1'b0;
            exp_rdy[i]  = 1'b0;
         end else if (phase[i] == 0) begin
            exp_rdy[i] = 1'b0;
            if (send_i) begin
               frame[i]    = buildFrame(i, data_i);
               k[i]        = 0;
               phase[i]    = 1;
               exp_tx[i]   = 1'b0;
               exp_busy[i] = 1'b1;
            end
         end else if (phase[i] == 1) begin
            k[i]++;
            if (k[i] == frameLen(i)) begin
               phase[i]    = 2;
               exp_tx[i]   = 1'b1;
               exp_busy[i] = 1'b0;
               exp_rdy[i]  = 1'b1;
            end else begin
               exp_tx[i] = frame[i][k[i] / cpbOf(i)];
            end
         end else begin
            exp_rdy[i] = 1'b0;
            exp_tx[i]  = 1'b1;
            if (!send_i) phase[i] = 0;
         end
      end
   end

   // every cycle, compare each instance against the model
   always @(negedge clk_i) begin
      if (check_en) begin
         for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("tx%0d", i), 32'(tx_w[i]), 32'(exp_tx[i]));
            checkOutput($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(exp_busy[i]));
            checkOutput($sformatf("rdy%0d", i), 32'(rdy_w[i]), 32'(exp_rdy[i]));
         end
      end
   end

   // one request; send drops one cycle after dut0's tx_rdy pulse, and no earlier than 'hold'
   task automatic runFrame(input string name, input logic [7:0] d, input int hold,
                           input int chg_at, input logic [7:0] d2);
      int start, rel, drop_at;
      int lat[4];
      int pulses[4];
      bit done;
      drop_at = -1;
      for (int i = 0; i < 4; i++) begin
         lat[i]    = -1;
         pulses[i] = 0;
      end
      applyStimulus(1'b1, d);
      start = cyc + 1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk_i);
         rel = cyc - start;
         for (int i = 0; i < 4; i++) begin
            if (rdy_w[i] === 1'b1) begin
               pulses[i]++;
               if (lat[i] < 0) lat[i] = rel;
            end
         end
         if (rel == 38) begin
            checkOutput({name, "_par_even"}, 32'(tx_w[1]), 32'(^d));
            checkOutput({name, "_par_odd"}, 32'(tx_w[2]), 32'(~^d));
         end
         if (rel == chg_at) data_i = d2;
         if (lat[0] >= 0 && drop_at < 0) drop_at = rel + 1;
         if (drop_at >= 0 && rel >= drop_at && rel >= hold) send_i = 1'b0;
         done = (send_i == 1'b0);
         for (int i = 0; i < 4; i++) if (lat[i] < 0) done = 1'b0;
         if (done) break;
      end
      send_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("%s_lat%0d", name, i), 32'(lat[i]), 32'(frameLen(i)));
         checkOutput($sformatf("%s_pulses%0d", name, i), 32'(pulses[i]), 32'd1);
      end
      repeat (3) @(negedge clk_i);
   endtask

   // reset 17 edges into a frame: line released at once, no tx_rdy afterwards
   task automatic resetMidFrame();
      int start;
      int pulses;
      applyStimulus(1'b1, 8'h5A);
      start = cyc + 1;
      while (cyc < start + 16) @(negedge clk_i);
      reset_i = 1'b0;
      send_i  = 1'b0;
      @(negedge clk_i);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("abort_tx%0d", i), 32'(tx_w[i]), 32'd1);
         checkOutput($sformatf("abort_busy%0d", i), 32'(busy_w[i]), 32'd0);
      end
      reset_i = 1'b1;
      pulses  = 0;
      repeat (60) begin
         @(negedge clk_i);
         if (rdy_w != 4'b0000) pulses++;
      end
      checkOutput("abort_no_rdy", 32'(pulses), 32'd0);
   endtask

   // dut3 handshake: send low for one cycle after tx_rdy, then the next request
   task automatic backToBack();
      int start1, start2, r1, t0, r2;
      r1 = -1;
      t0 = -1;
      r2 = -1;
      applyStimulus(1'b1, 8'h96);
      start1 = cyc + 1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk_i);
         if (rdy_w[3] === 1'b1) begin
            r1 = cyc;
            break;
         end
      end
      send_i = 1'b0;
      data_i = 8'h69;
      @(negedge clk_i);
      send_i = 1'b1;
      start2 = cyc + 1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk_i);
         if (t0 < 0 && tx_w[3] === 1'b0) t0 = cyc;
         if (rdy_w[3] === 1'b1) begin
            r2 = cyc;
            break;
         end
      end
      send_i = 1'b0;
      checkOutput("b2b_lat1", 32'(r1 - start1), 32'd11);
      checkOutput("b2b_gap", 32'(t0 - r1), 32'd2);
      checkOutput("b2b_lat2", 32'(r2 - start2), 32'd11);
      repeat (60) @(negedge clk_i);
   endtask

   // bounded run time
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // main sequence
   initial begin
      reset_i = 1'b0;
      send_i  = 1'b0;
      data_i  = 8'h00;
      repeat (2) @(negedge clk_i);
      check_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("rst_tx%0d", i), 32'(tx_w[i]), 32'd1);
         checkOutput($sformatf("rst_busy%0d", i), 32'(busy_w[i]), 32'd0);
         checkOutput($sformatf("rst_rdy%0d", i), 32'(rdy_w[i]), 32'd0);
      end
      reset_i = 1'b1;
      repeat (2) @(negedge clk_i);

      $display("[TB] basic frame 0xA5 with parity variants");
      runFrame("t1", 8'hA5, 0, -1, 8'h00);
      $display("[TB] send held high for 100 cycles");
      runFrame("t3", 8'h3C, 100, -1, 8'h00);
      $display("[TB] data_i changes mid-frame");
      runFrame("t4", 8'h0F, 0, 10, 8'hF0);
      $display("[TB] reset mid-frame");
      resetMidFrame();
      runFrame("t5", 8'hC3, 0, -1, 8'h00);
      $display("[TB] back-to-back frames");
      backToBack();

      $display("[TB] randomized stimulus");
      for (int n = 0; n < 600; n++) begin
         @(negedge clk_i);
         reset_i = ($urandom_range(0, 79) != 0);
         send_i  = ($urandom_range(0, 3) != 0);
         data_i  = 8'($urandom);
      end
      @(negedge clk_i);
      reset_i = 1'b1;
      send_i  = 1'b0;
      repeat (60) @(negedge clk_i);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
